line_fill_native: RTL and testbench



---
 rtl/line_fill_native_pkg.sv | 38 +++
 rtl/line_fill_native_if.sv | 61 ++++++
 rtl/line_fill_native_line_assembly_regs.sv | 45 ++++
 rtl/line_fill_native.sv | 170 +++++++++++++++++
 tb/tb_line_fill_native.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_fill_native_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_fill_native_pkg
// Description : Shared cache package. Holds the line-fill state encoding and
//               the line-geometry derivations that the line-fill sequencer
//               and read_channel_native both use.
// Revision    : 1.0 - initial release
// ============================================================================
package line_fill_native_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_FILL   = 2'd2,
        ST_COMMIT = 2'd3
    } fill_state_t;

    // log2 of back-end beats per cache line
    function automatic int calc_line2mem_w(input int word_off_w, input int fe_data_w,
                                           input int be_data_w);
        return word_off_w - $clog2(be_data_w / fe_data_w);
    endfunction

    function automatic int calc_beats(input int line2mem_w);
        return 1 << line2mem_w;
    endfunction

    function automatic int calc_line_w(input int fe_data_w, input int word_off_w);
        return fe_data_w << word_off_w;
    endfunction

    // Beat-index width; kept at least 1 bit so single-beat lines still have a port
    function automatic int calc_ra_w(input int line2mem_w);
        return (line2mem_w > 0) ? line2mem_w : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_fill_native_if.sv
`default_nettype none
// ============================================================================
// Module      : line_fill_native_if
// Description : Handshake bundle of the line-fill sequencer.
//               fill_*    : fill request from cache control
//               replace_* : line request into read_channel_native
//               read_*    : back-end beats of the requested block
//               crit_*    : critical-word forward
//               line_*    : assembled line to the data-memory write port
//               Modport slave is the sequencer side, master the surrounding
//               cache / back-end side.
// Revision    : 1.0 - initial release
// ============================================================================
interface line_fill_native_if
    import line_fill_native_pkg::*;
#(
    parameter int FE_ADDR_W  = 32,
    parameter int FE_DATA_W  = 32,
    parameter int BE_DATA_W  = 32,
    parameter int WORD_OFF_W = 3
);
    localparam int c_FE_BYTE_W  = $clog2(FE_DATA_W / 8);
    localparam int c_BE_BYTE_W  = $clog2(BE_DATA_W / 8);
    localparam int c_LINE2MEM_W = calc_line2mem_w(WORD_OFF_W, FE_DATA_W, BE_DATA_W);
    localparam int c_RA_W       = calc_ra_w(c_LINE2MEM_W);
    localparam int c_LINE_W     = calc_line_w(FE_DATA_W, WORD_OFF_W);
    localparam int c_FA_W       = FE_ADDR_W - c_FE_BYTE_W;
    localparam int c_LA_W       = FE_ADDR_W - c_BE_BYTE_W - c_LINE2MEM_W;

    logic                  fill_valid;
    logic [c_FA_W-1:0]     fill_addr;
    logic                  fill_ready;
    logic                  replace_valid;
    logic [c_LA_W-1:0]     replace_addr;
    logic                  replace_ready;
    logic                  read_valid;
    logic [c_RA_W-1:0]     read_addr;
    logic [BE_DATA_W-1:0]  read_rdata;
    logic                  crit_valid;
    logic [FE_DATA_W-1:0]  crit_rdata;
    logic                  line_valid;
    logic [c_LA_W-1:0]     line_addr;
    logic [c_LINE_W-1:0]   line_data;
    logic                  line_ready;

    modport slave (
        input  fill_valid, fill_addr, replace_ready, read_valid, read_addr,
               read_rdata, line_ready,
        output fill_ready, replace_valid, replace_addr, crit_valid, crit_rdata,
               line_valid, line_addr, line_data
    );

    modport master (
        output fill_valid, fill_addr, replace_ready, read_valid, read_addr,
               read_rdata, line_ready,
        input  fill_ready, replace_valid, replace_addr, crit_valid, crit_rdata,
               line_valid, line_addr, line_data
    );

endinterface
`default_nettype wire

// File: rtl/line_fill_native_line_assembly_regs.sv
`default_nettype none
// ============================================================================
// Module      : line_assembly_regs
// Description : Beat-indexed BEATS x BE_DATA_W register bank. A write strobe
//               stores wr_data into slot wr_idx; all slots are presented as
//               one flat line (slot i at [i*BE_DATA_W +: BE_DATA_W]).
//   clk, reset : clock, asynchronous active-low reset (clears every slot)
//   wr_en      : write strobe
//   wr_idx     : slot index
//   wr_data    : beat data
//   line_data  : flat line output
// Revision    : 1.0 - initial release
// ============================================================================
module line_assembly_regs #(
    parameter int BEATS     = 8,
    parameter int BE_DATA_W = 32,
    parameter int IDX_W     = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [BE_DATA_W-1:0]       wr_data,
    output logic [BEATS*BE_DATA_W-1:0] line_data
);

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_slot
            logic [BE_DATA_W-1:0] r_slot;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_slot <= '0;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    r_slot <= wr_data;
                end
            end

            assign line_data[gi*BE_DATA_W +: BE_DATA_W] = r_slot;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/line_fill_native.sv
`default_nettype none
// ============================================================================
// Module      : line_fill_native
// Description : Line-fill sequencer for the cache miss path. Accepts a word
//               address fill request, requests the line from the read
//               channel, assembles the returning beats into a full line,
//               forwards the critical word as soon as its beat lands, then
//               offers the line to the data-memory write port.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : line_fill_native_if.slave (fill / replace / read / crit / line)
// Revision    : 1.0 - initial release
// ============================================================================
module line_fill_native
    import line_fill_native_pkg::*;
#(
    parameter int FE_ADDR_W  = 32,
    parameter int FE_DATA_W  = 32,
    parameter int BE_DATA_W  = 32,
    parameter int WORD_OFF_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    line_fill_native_if.slave    bus
);

    localparam int c_FE_BYTE_W  = $clog2(FE_DATA_W / 8);
    localparam int c_BE_BYTE_W  = $clog2(BE_DATA_W / 8);
    localparam int c_LINE2MEM_W = calc_line2mem_w(WORD_OFF_W, FE_DATA_W, BE_DATA_W);
    localparam int c_BEATS      = calc_beats(c_LINE2MEM_W);
    localparam int c_RA_W       = calc_ra_w(c_LINE2MEM_W);
    localparam int c_SUB_W      = WORD_OFF_W - c_LINE2MEM_W;
    localparam int c_FA_W       = FE_ADDR_W - c_FE_BYTE_W;
    localparam int c_LA_W       = FE_ADDR_W - c_BE_BYTE_W - c_LINE2MEM_W;

    fill_state_t              r_state;
    fill_state_t              w_state_next;
    logic [c_LA_W-1:0]        r_line_addr;
    logic [WORD_OFF_W-1:0]    r_woff;
    logic [c_RA_W-1:0]        r_cnt;
    logic                     r_crit_done;
    logic                     r_crit_valid;
    logic [FE_DATA_W-1:0]     r_crit_rdata;

    logic                     w_beat;
    logic                     w_last_beat;
    logic                     w_crit_hit;
    logic [c_RA_W-1:0]        w_beat_idx;
    logic [FE_DATA_W-1:0]     w_crit_word;
    logic                     w_fill_ready;
    logic                     w_replace_valid;
    logic                     w_line_valid;

    // Beats only count while a fill is outstanding
    assign w_beat      = (r_state == ST_FILL) && bus.read_valid;
    assign w_last_beat = w_beat && (r_cnt == c_RA_W'(c_BEATS - 1));

    generate
        if (c_LINE2MEM_W > 0) begin : g_multi_beat
            assign w_beat_idx = bus.read_addr;
            assign w_crit_hit = (bus.read_addr == r_woff[WORD_OFF_W-1:c_SUB_W]);
        end else begin : g_single_beat
            // One beat carries the whole line, so it is always the critical beat
            logic w_unused_read_addr;
            assign w_unused_read_addr = ^bus.read_addr;
            assign w_beat_idx         = '0;
            assign w_crit_hit         = 1'b1;
        end
    endgenerate

    generate
        if (c_SUB_W > 0) begin : g_sub_word
            logic [c_SUB_W-1:0] w_sub;
            assign w_sub       = r_woff[c_SUB_W-1:0];
            assign w_crit_word = bus.read_rdata[int'(w_sub) * FE_DATA_W +: FE_DATA_W];
        end else begin : g_full_word
            assign w_crit_word = bus.read_rdata;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: handshake outputs decode from registered state only
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_fill_ready    = 1'b0;
        w_replace_valid = 1'b0;
        w_line_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_fill_ready = 1'b1;
                if (bus.fill_valid) w_state_next = ST_REQ;
            end
            ST_REQ: begin
                w_replace_valid = 1'b1;
                if (bus.replace_ready) w_state_next = ST_FILL;
            end
            ST_FILL: begin
                if (w_last_beat) w_state_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_line_valid = 1'b1;
                if (bus.line_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, beat counter and critical-word forward
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_line_addr  <= '0;
            r_woff       <= '0;
            r_cnt        <= '0;
            r_crit_done  <= 1'b0;
            r_crit_valid <= 1'b0;
            r_crit_rdata <= '0;
        end else begin
            r_crit_valid <= 1'b0;
            if ((r_state == ST_IDLE) && bus.fill_valid) begin
                r_line_addr <= bus.fill_addr[c_FA_W-1:WORD_OFF_W];
                r_woff      <= bus.fill_addr[WORD_OFF_W-1:0];
                r_cnt       <= '0;
                r_crit_done <= 1'b0;
            end
            if (w_beat) begin
                // The last beat leaves FILL, so the counter is not advanced past it
                if (!w_last_beat) r_cnt <= r_cnt + 1'b1;
                if (w_crit_hit && !r_crit_done) begin
                    r_crit_valid <= 1'b1;
                    r_crit_rdata <= w_crit_word;
                    r_crit_done  <= 1'b1;
                end
            end
        end
    end

    line_assembly_regs #(
        .BEATS     (c_BEATS),
        .BE_DATA_W (BE_DATA_W),
        .IDX_W     (c_RA_W)
    ) u_line_regs (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (w_beat),
        .wr_idx    (w_beat_idx),
        .wr_data   (bus.read_rdata),
        .line_data (bus.line_data)
    );

    assign bus.fill_ready    = w_fill_ready;
    assign bus.replace_valid = w_replace_valid;
    assign bus.replace_addr  = r_line_addr;
    assign bus.line_valid    = w_line_valid;
    assign bus.line_addr     = r_line_addr;
    assign bus.crit_valid    = r_crit_valid;
    assign bus.crit_rdata    = r_crit_rdata;

endmodule
`default_nettype wire

// File: tb/tb_line_fill_native.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_fill_native
// Description : Self-checking bench for line_fill_native. A table of fill
//               records drives the default (32/32) instance; a scoreboard
//               holds expected critical words and lines with their due cycle.
//               Hand sequences cover reset mid-fill and a 64-bit back end.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_fill_native;

    logic clk = 1'b0;
    logic reset;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    logic lv_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    line_fill_native_if #(.FE_ADDR_W(32), .FE_DATA_W(32), .BE_DATA_W(32), .WORD_OFF_W(3)) bus ();
    line_fill_native_if #(.FE_ADDR_W(32), .FE_DATA_W(32), .BE_DATA_W(64), .WORD_OFF_W(3)) bus_w ();

    line_fill_native #(.FE_ADDR_W(32), .FE_DATA_W(32), .BE_DATA_W(32), .WORD_OFF_W(3)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    line_fill_native #(.FE_ADDR_W(32), .FE_DATA_W(32), .BE_DATA_W(64), .WORD_OFF_W(3)) u_dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w)
    );

    typedef struct {
        logic [28:0] fa;
        logic [31:0] base;
        bit          rev;
        int          req_stall;
        int          commit_stall;
        bit          spur;
        logic [25:0] exp_la;
        logic [31:0] exp_crit;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } crit_exp_t;

    typedef struct {
        int           cyc;
        logic [25:0]  addr;
        logic [255:0] data;
    } line_exp_t;

    crit_exp_t    crit_q[$];
    line_exp_t    line_q[$];
    crit_exp_t    mon_ce;
    line_exp_t    mon_le;
    vec_t         vecs[7];
    logic [255:0] last_line;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: crit pulses and line_valid rises must match the
    // queued expectation in both value and cycle.
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            if (bus.crit_valid === 1'b1) begin
                if (crit_q.size() == 0) begin
                    check("crit_unexpected", 256'(1), 256'(0));
                end else begin
                    mon_ce = crit_q.pop_front();
                    check("crit_cycle", 256'(cyc), 256'(mon_ce.cyc));
                    check("crit_rdata", 256'(bus.crit_rdata), 256'(mon_ce.data));
                end
            end
            if ((bus.line_valid === 1'b1) && !lv_prev) begin
                if (line_q.size() == 0) begin
                    check("line_unexpected", 256'(1), 256'(0));
                end else begin
                    mon_le = line_q.pop_front();
                    check("line_cycle", 256'(cyc), 256'(mon_le.cyc));
                    check("line_addr", 256'(bus.line_addr), 256'(mon_le.addr));
                    check("line_data", bus.line_data, mon_le.data);
                end
            end
        end
        lv_prev = bus.line_valid;
    end

    task automatic do_fill(input vec_t v);
        logic [255:0] exp_line;
        int crit_idx;
        int idx;
        crit_idx = int'(v.fa[2:0]);
        for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = v.base + 32'(i);

        check("fill_ready_idle", 256'(bus.fill_ready), 256'(1));
        bus.fill_valid    = 1'b1;
        bus.fill_addr     = v.fa;
        bus.replace_ready = 1'b0;
        if (v.spur) begin
            bus.read_valid = 1'b1;
            bus.read_addr  = 3'(crit_idx);
            bus.read_rdata = 32'hDEAD;
        end
        tick();
        bus.fill_valid = 1'b0;
        bus.read_valid = 1'b0;
        check("idle_line_kept", bus.line_data, last_line);

        for (int s = 0; s < v.req_stall; s++) begin
            check("replace_valid_stall", 256'(bus.replace_valid), 256'(1));
            check("replace_addr_stall", 256'(bus.replace_addr), 256'(v.exp_la));
            if (v.spur) begin
                bus.read_valid = 1'b1;
                bus.read_addr  = 3'(crit_idx);
                bus.read_rdata = 32'hDEAD;
            end
            tick();
            bus.read_valid = 1'b0;
            check("req_line_kept", bus.line_data, last_line);
        end
        check("replace_valid", 256'(bus.replace_valid), 256'(1));
        check("replace_addr", 256'(bus.replace_addr), 256'(v.exp_la));
        bus.replace_ready = 1'b1;
        tick();
        bus.replace_ready = 1'b0;
        check("replace_valid_fill", 256'(bus.replace_valid), 256'(0));

        for (int k = 0; k < 8; k++) begin
            idx = v.rev ? 7 - k : k;
            bus.read_valid = 1'b1;
            bus.read_addr  = 3'(idx);
            bus.read_rdata = v.base + 32'(idx);
            if (idx == crit_idx) crit_q.push_back('{cyc + 1, v.exp_crit});
            if (k == 7) line_q.push_back('{cyc + 1, v.exp_la, exp_line});
            tick();
        end
        bus.read_valid = 1'b0;

        for (int s = 0; s < v.commit_stall; s++) begin
            check("line_valid_hold", 256'(bus.line_valid), 256'(1));
            check("line_data_hold", bus.line_data, exp_line);
            check("fill_ready_busy", 256'(bus.fill_ready), 256'(0));
            bus.fill_valid = 1'b1;
            bus.fill_addr  = ~v.fa;
            tick();
        end
        bus.fill_valid = 1'b0;
        check("line_valid_commit", 256'(bus.line_valid), 256'(1));
        bus.line_ready = 1'b1;
        tick();
        bus.line_ready = 1'b0;
        check("line_valid_drop", 256'(bus.line_valid), 256'(0));
        check("fill_ready_back", 256'(bus.fill_ready), 256'(1));
        check("crit_q_drained", 256'(crit_q.size()), 256'(0));
        check("line_q_drained", 256'(line_q.size()), 256'(0));
        last_line = exp_line;
    endtask

    task automatic check_reset_values();
        check("rst_fill_ready", 256'(bus.fill_ready), 256'(1));
        check("rst_replace_valid", 256'(bus.replace_valid), 256'(0));
        check("rst_crit_valid", 256'(bus.crit_valid), 256'(0));
        check("rst_line_valid", 256'(bus.line_valid), 256'(0));
        check("rst_crit_rdata", 256'(bus.crit_rdata), 256'(0));
        check("rst_line_data", bus.line_data, 256'(0));
        check("rst_line_addr", 256'(bus.line_addr), 256'(0));
        check("rst_replace_addr", 256'(bus.replace_addr), 256'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0]  beat;
        logic [255:0] wexp;

        vecs[0] = '{29'h48D,      32'hA0,       1'b0, 0, 0, 1'b0, 26'h91,      32'hA5};
        vecs[1] = '{29'h48D,      32'hA0,       1'b0, 3, 0, 1'b0, 26'h91,      32'hA5};
        vecs[2] = '{29'h48D,      32'hA0,       1'b0, 0, 4, 1'b0, 26'h91,      32'hA5};
        vecs[3] = '{29'h000,      32'h100,      1'b1, 0, 0, 1'b0, 26'h0,       32'h100};
        vecs[4] = '{29'h007,      32'h200,      1'b0, 0, 0, 1'b0, 26'h0,       32'h207};
        vecs[5] = '{29'h1FFFFFFF, 32'h300,      1'b1, 1, 0, 1'b0, 26'h3FFFFFF, 32'h307};
        vecs[6] = '{29'h123456,   32'hBEEF0000, 1'b0, 2, 1, 1'b1, 26'h2468A,   32'hBEEF0006};

        reset = 1'b0;
        bus.fill_valid = 1'b0;   bus.fill_addr = '0;   bus.replace_ready = 1'b0;
        bus.read_valid = 1'b0;   bus.read_addr = '0;   bus.read_rdata = '0;
        bus.line_ready = 1'b0;
        bus_w.fill_valid = 1'b0; bus_w.fill_addr = '0; bus_w.replace_ready = 1'b0;
        bus_w.read_valid = 1'b0; bus_w.read_addr = '0; bus_w.read_rdata = '0;
        bus_w.line_ready = 1'b0;
        last_line = '0;

        tick();
        tick();
        check_reset_values();
        reset = 1'b1;
        tick();
        mon_en = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_fill(vecs[i]);
            tick();
        end

        // Reset in the middle of a fill, after three of eight beats
        bus.fill_valid = 1'b1;
        bus.fill_addr  = 29'h48D;
        tick();
        bus.fill_valid    = 1'b0;
        bus.replace_ready = 1'b1;
        tick();
        bus.replace_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.read_valid = 1'b1;
            bus.read_addr  = 3'(k);
            bus.read_rdata = 32'hC0 + 32'(k);
            tick();
        end
        bus.read_valid = 1'b0;
        mon_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_values();
        tick();
        tick();
        reset = 1'b1;
        crit_q.delete();
        line_q.delete();
        last_line = '0;
        tick();
        mon_en = 1'b1;
        do_fill(vecs[0]);
        tick();

        // 64-bit back end: four beats, woff = 5 -> beat 2, upper half
        bus_w.fill_valid = 1'b1;
        bus_w.fill_addr  = 29'h48D;
        tick();
        bus_w.fill_valid = 1'b0;
        check("w_replace_valid", 256'(bus_w.replace_valid), 256'(1));
        check("w_replace_addr", 256'(bus_w.replace_addr), 256'(27'h91));
        bus_w.replace_ready = 1'b1;
        tick();
        bus_w.replace_ready = 1'b0;
        wexp = '0;
        for (int k = 0; k < 4; k++) begin
            beat = (k == 2) ? 64'h1111_2222_3333_4444
                            : {32'hB1 + 32'(2 * k), 32'hB0 + 32'(2 * k)};
            wexp[k*64 +: 64] = beat;
            bus_w.read_valid = 1'b1;
            bus_w.read_addr  = 2'(k);
            bus_w.read_rdata = beat;
            tick();
            check("w_crit_valid", 256'(bus_w.crit_valid), 256'(k == 2));
            check("w_line_valid", 256'(bus_w.line_valid), 256'(k == 3));
            if (k == 2) check("w_crit_rdata", 256'(bus_w.crit_rdata), 256'(32'h1111_2222));
        end
        bus_w.read_valid = 1'b0;
        check("w_line_data", bus_w.line_data, wexp);
        check("w_line_addr", 256'(bus_w.line_addr), 256'(27'h91));
        bus_w.line_ready = 1'b1;
        tick();
        bus_w.line_ready = 1'b0;
        check("w_line_valid_drop", 256'(bus_w.line_valid), 256'(0));
        check("w_fill_ready_back", 256'(bus_w.fill_ready), 256'(1));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
